// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  // Controller states:
  //   IDLE  | waiting for start, result held
  //   SHIFT | one operand bit pair consumed per clock
  //   DONE  | one-cycle window where sum/cout are final
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Bit counter width: clog2(n), never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// Single-bit full adder built from two half-adder cells and an OR.

// Half adder: sum is XOR, carry is AND.
module half_adder_cell (
  input  logic i_a,
  input  logic i_b,
  output logic o_sum,
  output logic o_carry
);
  assign o_sum   = i_a ^ i_b;
  assign o_carry = i_a & i_b;
endmodule

// Full adder: at most one of the two half-adder carries can be high,
// so an OR is enough to merge them.
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  logic w_s1;
  logic w_c1;
  logic w_c2;

  half_adder_cell u_ha0 (
    .i_a     (x),
    .i_b     (y),
    .o_sum   (w_s1),
    .o_carry (w_c1)
  );

  half_adder_cell u_ha1 (
    .i_a     (w_s1),
    .i_b     (ci),
    .o_sum   (s),
    .o_carry (w_c2)
  );

  assign co = w_c1 | w_c2;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: operands consumed LSB-first, one bit per clock,
// result assembled MSB-in in the sum register, start/done handshake.
//
//   state | meaning
//   IDLE  | waiting for start; sum/cout hold the last result
//   SHIFT | busy=1; one bit pair added per clock, N clocks total
//   DONE  | done=1 for one cycle; start here is accepted back-to-back
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int CW = cnt_width(N);

  state_t          r_state;
  state_t          w_state_next;
  logic [N-1:0]    r_a_sr;
  logic [N-1:0]    r_b_sr;
  logic [N-1:0]    r_sum;
  logic            r_carry;
  logic [CW-1:0]   r_cnt;
  logic            w_accept;
  logic            w_last;
  logic            w_s;
  logic            w_co;
  logic [N-1:0]    w_sum_next;

  full_adder_cell u_fa (
    .x  (r_a_sr[0]),
    .y  (r_b_sr[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  // Last SHIFT edge is the one where the counter already reads N-1.
  assign w_last = (r_cnt == CW'(N - 1));

  // New bit enters at the MSB; written as a shift/OR so N=1 needs no special case.
  assign w_sum_next = (r_sum >> 1) | (N'(w_s) << (N - 1));

  assign sum  = r_sum;
  assign cout = r_carry;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode plus busy/done, both derived purely from state.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = SHIFT;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Datapath: load operands on accept, otherwise shift one bit per SHIFT clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a_sr  <= a;
      r_b_sr  <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (r_state == SHIFT) begin
      r_a_sr  <= r_a_sr >> 1;
      r_b_sr  <= r_b_sr >> 1;
      r_sum   <= w_sum_next;
      r_carry <= w_co;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at N=8 and N=1.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       s8, c8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       s1, c1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  serial_adder #(.N(8)) u8 (
    .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .cin(c8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.N(1)) u1 (
    .clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1), .cin(c1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; start is held across exactly one rising edge.
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c);
    s8 = 1'b1; a8 = a; b8 = b; c8 = c;
    @(posedge clk); #1;
    s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
  endtask

  task automatic start1(input logic a, input logic b, input logic c);
    s1 = 1'b1; a1 = a; b1 = b; c1 = c;
    @(posedge clk); #1;
    s1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
  endtask

  // Counts cycles after the accept edge until done; returns at done's negedge.
  task automatic wait_done8(output int lat, output int nb);
    bit both;
    both = 0; lat = 0; nb = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy8) nb++;
      if (busy8 && done8) both = 1;
    end while (!done8 && lat < 40);
    check("busy_done_exclusive_n8", 64'(both), 64'd0);
  endtask

  task automatic wait_done1(output int lat, output int nb);
    bit both;
    both = 0; lat = 0; nb = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy1) nb++;
      if (busy1 && done1) both = 1;
    end while (!done1 && lat < 40);
    check("busy_done_exclusive_n1", 64'(both), 64'd0);
  endtask

  initial begin
    int lat, nb;
    bit seen;
    logic [8:0] exp9;
    logic [1:0] exp2;
    logic [7:0] ra, rb;
    logic       rc;
    logic       ra1, rb1;

    vecs[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{8'h80, 8'h7F, 1'b0, 8'hFF, 1'b0};
    vecs[7] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};

    rst = 1'b1;
    s8 = 0; a8 = 8'h00; b8 = 8'h00; c8 = 0;
    s1 = 0; a1 = 1'b0; b1 = 1'b0; c1 = 0;
    #1;
    check("reset_outputs_n8", {busy8, done8, cout8, sum8}, 64'd0);
    check("reset_outputs_n1", {busy1, done1, cout1, sum1}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {busy8, done8}, 64'd0);

    // Directed vectors: latency, busy width, result, single-cycle done, held result.
    for (int i = 0; i < 8; i++) begin
      start8(vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_done8(lat, nb);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd9);
      check($sformatf("vec%0d_busy_cycles", i), 64'(nb), 64'd8);
      check($sformatf("vec%0d_sum", i), 64'(sum8), 64'(vecs[i].exp_sum));
      check($sformatf("vec%0d_cout", i), 64'(cout8), 64'(vecs[i].exp_cout));
      @(negedge clk);
      check($sformatf("vec%0d_done_single", i), 64'(done8), 64'd0);
      check($sformatf("vec%0d_sum_held", i), {cout8, sum8}, {vecs[i].exp_cout, vecs[i].exp_sum});
    end

    // start re-pulsed during SHIFT cycle 3 must be ignored.
    start8(8'h12, 8'h34, 1'b0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 3) begin
        s8 = 1'b1; a8 = 8'hAA; b8 = 8'hAA; c8 = 1'b1;
      end else begin
        s8 = 1'b0;
      end
    end while (!done8 && lat < 40);
    s8 = 1'b0;
    check("repulse_latency", 64'(lat), 64'd9);
    check("repulse_result", {cout8, sum8}, {1'b0, 8'h46});
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) seen = 1;
    end
    check("repulse_no_second_op", 64'(seen), 64'd0);

    // Back-to-back: start held in the DONE cycle.
    start8(8'h11, 8'h22, 1'b0);
    wait_done8(lat, nb);
    check("b2b_first_result", {cout8, sum8}, {1'b0, 8'h33});
    start8(8'h80, 8'h80, 1'b0);
    wait_done8(lat, nb);
    check("b2b_second_latency", 64'(lat), 64'd9);
    check("b2b_second_result", {cout8, sum8}, {1'b1, 8'h00});
    @(negedge clk);

    // Asynchronous reset between edges in SHIFT cycle 4.
    start8(8'h55, 8'h66, 1'b0);
    repeat (4) @(negedge clk);
    check("pre_reset_busy", 64'(busy8), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", {busy8, done8, cout8, sum8}, 64'd0);
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (done8) seen = 1;
    end
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) seen = 1;
    end
    check("no_done_after_abort", 64'(seen), 64'd0);
    start8(8'h01, 8'h02, 1'b1);
    wait_done8(lat, nb);
    check("post_reset_latency", 64'(lat), 64'd9);
    check("post_reset_result", {cout8, sum8}, {1'b0, 8'h04});
    @(negedge clk);

    // N=1 directed.
    start1(1'b1, 1'b1, 1'b1);
    wait_done1(lat, nb);
    check("n1_latency", 64'(lat), 64'd2);
    check("n1_busy_cycles", 64'(nb), 64'd1);
    check("n1_result", {cout1, sum1}, 64'b11);
    @(negedge clk);

    // Random N=8, gap 0 means start lands in the DONE cycle.
    for (int i = 0; i < 250; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start8(ra, rb, rc);
      wait_done8(lat, nb);
      exp9 = 9'(ra) + 9'(rb) + 9'(rc);
      check("rand8_latency", 64'(lat), 64'd9);
      check("rand8_result", {cout8, sum8}, 64'(exp9));
    end
    @(negedge clk);

    // Random N=1.
    for (int i = 0; i < 250; i++) begin
      ra1 = 1'($urandom); rb1 = 1'($urandom); rc = 1'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start1(ra1, rb1, rc);
      wait_done1(lat, nb);
      exp2 = 2'(ra1) + 2'(rb1) + 2'(rc);
      check("rand1_latency", 64'(lat), 64'd2);
      check("rand1_result", {cout1, sum1}, 64'(exp2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
